// File: rtl/escalonador_processos_if.sv
// rtl/escalonador_processos_if.sv - scheduler <-> CPU/SO signal bundle
interface escalonador_processos_if #(
   parameter int ID_W = 3,
   parameter int PC_W = 9
);
   logic            en_user;
   logic            quantum_over;
   logic            halt_proc;
   logic            criar_proc;
   logic [ID_W-1:0] criar_id;
   logic [PC_W-1:0] criar_pc;
   logic [PC_W-1:0] pc_atual;
   logic [ID_W-1:0] id_proc;
   logic [PC_W-1:0] pc_novo;
   logic            pc_load;
   logic            bloq_cpu;
   logic            todos_fim;

   modport master (
      output en_user, quantum_over, halt_proc, criar_proc, criar_id, criar_pc, pc_atual,
      input  id_proc, pc_novo, pc_load, bloq_cpu, todos_fim
   );

   modport slave (
      input  en_user, quantum_over, halt_proc, criar_proc, criar_id, criar_pc, pc_atual,
      output id_proc, pc_novo, pc_load, bloq_cpu, todos_fim
   );
endinterface

// File: rtl/escalonador_processos.sv
// rtl/escalonador_processos.sv - round-robin process scheduler with saved-PC table
// Id 0 is the SO; user slots 1..NUM_PROC. Context switch: SALVA -> SELECIONA -> RESTAURA.
module escalonador_processos #(
   parameter int NUM_PROC = 4,
   parameter int ID_W     = 3,
   parameter int PC_W     = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   escalonador_processos_if.slave  sched
);
   localparam logic [ID_W-1:0] L_MAX_ID = ID_W'(NUM_PROC);

   typedef enum logic [2:0] {
      OCIOSO,
      EXECUTA,
      SALVA,
      SELECIONA,
      RESTAURA
   } state_t;

   state_t          r_state;
   logic [ID_W-1:0] r_id;
   logic [ID_W-1:0] r_next;
   logic [PC_W-1:0] r_pc_novo;
   logic            r_pc_load;
   logic            r_bloq;
   logic            r_todos_fim;
   logic            r_qo_d;
   logic            r_ht_d;
   logic            r_cause_halt;
   logic [NUM_PROC:1] r_ready;
   logic [PC_W-1:0] r_ctx [1:NUM_PROC];

   logic              w_qo_ev;
   logic              w_ht_ev;
   logic              w_trig;
   logic              w_cria_ok;
   logic [NUM_PROC:1] w_cria_hit;
   logic [NUM_PROC:1] w_ready_eff;
   logic [PC_W-1:0]   w_ctx_eff [1:NUM_PROC];
   logic              w_found;
   logic [ID_W-1:0]   w_next;
   logic [PC_W-1:0]   w_next_pc;
   int                w_cand;

   assign w_qo_ev   = sched.quantum_over & ~r_qo_d;
   assign w_ht_ev   = sched.halt_proc & ~r_ht_d;
   assign w_trig    = sched.en_user & (w_qo_ev | w_ht_ev);
   assign w_cria_ok = sched.criar_proc && (sched.criar_id != '0) && (sched.criar_id <= L_MAX_ID);

   // A creation this cycle is already visible to the ready scan and the PC bypass.
   always_comb begin
      w_cria_hit  = '0;
      w_ready_eff = '0;
      for (int i = 1; i <= NUM_PROC; i++) begin
         w_cria_hit[i]  = w_cria_ok && (sched.criar_id == ID_W'(i));
         w_ready_eff[i] = r_ready[i] | w_cria_hit[i];
         w_ctx_eff[i]   = w_cria_hit[i] ? sched.criar_pc : r_ctx[i];
      end
   end

   // Scan starts just after the running id and wraps; from id 0 it starts at 1.
   always_comb begin
      w_found   = 1'b0;
      w_next    = '0;
      w_next_pc = '0;
      w_cand    = 0;
      for (int k = 1; k <= NUM_PROC; k++) begin
         w_cand = ((int'(r_id) + k - 1) % NUM_PROC) + 1;
         for (int i = 1; i <= NUM_PROC; i++) begin
            if (!w_found && (w_cand == i) && w_ready_eff[i]) begin
               w_found   = 1'b1;
               w_next    = ID_W'(i);
               w_next_pc = w_ctx_eff[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= OCIOSO;
         r_id         <= '0;
         r_next       <= '0;
         r_pc_novo    <= '0;
         r_pc_load    <= 1'b0;
         r_bloq       <= 1'b0;
         r_todos_fim  <= 1'b1;
         r_qo_d       <= 1'b0;
         r_ht_d       <= 1'b0;
         r_cause_halt <= 1'b0;
         r_ready      <= '0;
         for (int i = 1; i <= NUM_PROC; i++) r_ctx[i] <= '0;
      end else begin
         r_qo_d    <= sched.quantum_over;
         r_ht_d    <= sched.halt_proc;
         r_pc_load <= 1'b0;

         // Creation overrides any same-cycle retire/save of that slot.
         for (int i = 1; i <= NUM_PROC; i++) begin
            if (w_cria_hit[i]) begin
               r_ready[i] <= 1'b1;
               r_ctx[i]   <= sched.criar_pc;
            end else if ((r_state == SALVA) && (r_id == ID_W'(i))) begin
               if (r_cause_halt) r_ready[i] <= 1'b0;
               else              r_ctx[i]   <= sched.pc_atual;
            end
         end

         case (r_state)
            OCIOSO: begin
               if (|w_ready_eff) begin
                  r_state     <= SELECIONA;
                  r_bloq      <= 1'b1;
                  r_todos_fim <= 1'b0;
               end
            end
            EXECUTA: begin
               if (w_trig) begin
                  r_state      <= SALVA;
                  r_bloq       <= 1'b1;
                  r_cause_halt <= w_ht_ev;
               end
            end
            SALVA: begin
               r_state <= SELECIONA;
            end
            SELECIONA: begin
               if (w_found) begin
                  r_state   <= RESTAURA;
                  r_next    <= w_next;
                  r_id      <= w_next;
                  r_pc_novo <= w_next_pc;
                  r_pc_load <= 1'b1;
               end else begin
                  r_state     <= OCIOSO;
                  r_id        <= '0;
                  r_bloq      <= 1'b0;
                  r_todos_fim <= 1'b1;
               end
            end
            RESTAURA: begin
               r_state <= EXECUTA;
               r_id    <= r_next;
               r_bloq  <= 1'b0;
            end
            default: begin
               r_state <= OCIOSO;
            end
         endcase
      end
   end

   assign sched.id_proc   = r_id;
   assign sched.pc_novo   = r_pc_novo;
   assign sched.pc_load   = r_pc_load;
   assign sched.bloq_cpu  = r_bloq;
   assign sched.todos_fim = r_todos_fim;
endmodule
